// File: rtl/axi4_single_beat_master.sv
// Single-outstanding AXI4 initiator: takes one command, issues one single-beat INCR
// write or read, and returns the response or a timeout indication.
module axi4_single_beat_master #(
    parameter int          AXI_ADDR_WIDTH   = 6,
    parameter int          AXI_DATA_WIDTH   = 128,
    parameter int          AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
    parameter logic [15:0] AXI_ID           = 16'h0000,
    parameter int          TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    // command / response
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_write_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [AXI_STROBE_WIDTH-1:0] cmd_wstrb_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]                  rsp_resp_o,
    output logic                        rsp_timeout_o,
    // AW
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr_o,
    output logic                        m_axi_awvalid_o,
    output logic [15:0]                 m_axi_awid_o,
    output logic [1:0]                  m_axi_awburst_o,
    output logic [2:0]                  m_axi_awsize_o,
    output logic [7:0]                  m_axi_awlen_o,
    output logic                        m_axi_awuser_o,
    input  logic                        m_axi_awready_i,
    // W
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata_o,
    output logic [AXI_STROBE_WIDTH-1:0] m_axi_wstrb_o,
    output logic                        m_axi_wvalid_o,
    output logic                        m_axi_wlast_o,
    input  logic                        m_axi_wready_i,
    // B
    input  logic                        m_axi_bvalid_i,
    input  logic [1:0]                  m_axi_bresp_i,
    input  logic [15:0]                 m_axi_bid_i,
    output logic                        m_axi_bready_o,
    // AR
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr_o,
    output logic                        m_axi_arvalid_o,
    output logic [15:0]                 m_axi_arid_o,
    output logic [1:0]                  m_axi_arburst_o,
    output logic [2:0]                  m_axi_arsize_o,
    output logic [7:0]                  m_axi_arlen_o,
    output logic                        m_axi_aruser_o,
    input  logic                        m_axi_arready_i,
    // R
    input  logic                        m_axi_rvalid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata_i,
    input  logic [1:0]                  m_axi_rresp_i,
    input  logic                        m_axi_rlast_i,
    input  logic [15:0]                 m_axi_rid_i,
    output logic                        m_axi_rready_o
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      BEAT_SZ  = 3'($clog2(AXI_STROBE_WIDTH));
    localparam logic [1:0]      RESP_ERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_AW_W, WAIT_B, RD_AR, WAIT_R, RSP} state_t;

    state_t                      state_q, state_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q, wvalid_d;
    logic                        bready_q, bready_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                  rsp_resp_q, rsp_resp_d;
    logic                        rsp_timeout_q, rsp_timeout_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    wstrb_d     = cmd_wstrb_i;
                    cmd_ready_d = 1'b0;
                    if (cmd_write_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W complete independently; B wait starts once both are done.
                if (awvalid_q && m_axi_awready_i) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready_i)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT_B;
                end
            end
            RD_AR: begin
                if (m_axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_R;
                end
            end
            WAIT_B: begin
                if (m_axi_bvalid_i) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = (m_axi_bid_i == AXI_ID) ? m_axi_bresp_i : RESP_ERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (cnt_q == CNT_LAST) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_ERR;
                    rsp_timeout_d = 1'b1;
                    state_d       = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_R: begin
                if (m_axi_rvalid_i) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi_rdata_i;
                    rsp_resp_d    = (m_axi_rid_i == AXI_ID && m_axi_rlast_i) ? m_axi_rresp_i
                                                                            : RESP_ERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (cnt_q == CNT_LAST) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_ERR;
                    rsp_timeout_d = 1'b1;
                    state_d       = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o     = cmd_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_resp_o      = rsp_resp_q;
    assign rsp_timeout_o   = rsp_timeout_q;

    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_awid_o    = AXI_ID;
    assign m_axi_awburst_o = 2'b01;
    assign m_axi_awsize_o  = BEAT_SZ;
    assign m_axi_awlen_o   = 8'd0;
    assign m_axi_awuser_o  = 1'b0;

    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_wlast_o   = 1'b1;
    assign m_axi_bready_o  = bready_q;

    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_arid_o    = AXI_ID;
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arsize_o  = BEAT_SZ;
    assign m_axi_arlen_o   = 8'd0;
    assign m_axi_aruser_o  = 1'b0;
    assign m_axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi4_single_beat_master.sv
// Directed bench for axi4_single_beat_master; slave side is driven by hand per vector.
module tb_axi4_single_beat_master;

    localparam int AW = 6;
    localparam int DW = 128;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, awuser, wvalid, wready, wlast;
    logic [15:0]   awid, arid, bid, rid;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [2:0]    awsize, arsize;
    logic [7:0]    awlen, arlen;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic          bvalid, bready, arvalid, arready, aruser, rvalid, rlast, rready;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    axi4_single_beat_master #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_STROBE_WIDTH(SW),
        .AXI_ID(16'h0000), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
        .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awid_o(awid),
        .m_axi_awburst_o(awburst), .m_axi_awsize_o(awsize), .m_axi_awlen_o(awlen),
        .m_axi_awuser_o(awuser), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid),
        .m_axi_wlast_o(wlast), .m_axi_wready_i(wready),
        .m_axi_bvalid_i(bvalid), .m_axi_bresp_i(bresp), .m_axi_bid_i(bid),
        .m_axi_bready_o(bready),
        .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arid_o(arid),
        .m_axi_arburst_o(arburst), .m_axi_arsize_o(arsize), .m_axi_arlen_o(arlen),
        .m_axi_aruser_o(aruser), .m_axi_arready_i(arready),
        .m_axi_rvalid_i(rvalid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
        .m_axi_rlast_i(rlast), .m_axi_rid_i(rid), .m_axi_rready_o(rready)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command; returns after the accepting edge with cmd_valid dropped.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = 16'hFFFF;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consume_rsp_valid", rsp_valid, 0);
        chk("consume_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 1; rid = 0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_resp, rsp_timeout, rsp_rdata}, 0);
        chk("rst_addr", awaddr, 0);
        chk("const_attrs", {awburst, awsize, awlen, wlast, arsize, arlen, awuser}, {2'b01, 3'd4, 8'd0, 1'b1, 3'd4, 8'd0, 1'b0});
        reset = 1'b0;
        tick();

        // write, ready slave: handshake cycle 1, bready cycle 2, rsp_valid cycle 3
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00; bid = 0;
        issue(1'b1, 6'h10, 128'h1);
        chk("w1_valids", {awvalid, wvalid, cmd_ready}, 3'b110);
        chk("w1_awaddr", awaddr, 6'h10);
        chk("w1_wdata", wdata, 128'h1);
        chk("w1_wstrb", wstrb, 16'hFFFF);
        tick();
        chk("w1_bready", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
        tick();
        chk("w1_rsp", {bready, rsp_valid, rsp_resp, rsp_timeout}, 5'b0_1_00_0);
        chk("w1_rdata", rsp_rdata, 0);
        consume();
        bvalid = 0;

        // write, awready delayed: awvalid held 5 cycles, wvalid gone after 1
        awready = 0; wready = 1;
        issue(1'b1, 6'h24, 128'hCAFE);
        chk("w2_c1", {awvalid, wvalid}, 2'b11);
        tick();
        chk("w2_c2", {awvalid, wvalid, bready}, 3'b100);
        tick(); tick(); tick();
        chk("w2_c5", {awvalid, wvalid, bready}, 3'b100);
        chk("w2_addr_stable", awaddr, 6'h24);
        chk("w2_data_stable", wdata, 128'hCAFE);
        awready = 1;
        tick();
        chk("w2_bready", {awvalid, bready}, 2'b01);
        bvalid = 1; bresp = 2'b01;
        tick();
        chk("w2_rsp", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1_01_0);
        consume();
        bvalid = 0;

        // write with wrong bid -> forced error response
        bid = 16'h0003;
        issue(1'b1, 6'h08, 128'h5);
        tick();
        bvalid = 1; bresp = 2'b00;
        tick();
        chk("w3_bid_err", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1_10_0);
        consume();
        bvalid = 0; bid = 0;

        // read 0x20, DEAD_BEEF
        arready = 1; rvalid = 1; rdata = 128'hDEAD_BEEF; rresp = 2'b00; rlast = 1; rid = 0;
        issue(1'b0, 6'h20, '0);
        chk("r1_ar", {arvalid, awvalid, wvalid}, 3'b100);
        chk("r1_araddr", araddr, 6'h20);
        tick();
        chk("r1_rready", {arvalid, rready}, 2'b01);
        tick();
        chk("r1_rsp", {rready, rsp_valid, rsp_resp, rsp_timeout}, 5'b0_1_00_0);
        chk("r1_rdata", rsp_rdata, 128'hDEAD_BEEF);
        rvalid = 0;
        // rsp_ready held low 5 cycles while a new command is offered
        cmd_valid = 1; cmd_write = 0; cmd_addr = 6'h30;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rsp", {rsp_valid, rsp_resp, rsp_timeout, cmd_ready, arvalid}, 6'b1_00_0_0_0);
            chk("hold_rdata", rsp_rdata, 128'hDEAD_BEEF);
        end
        cmd_valid = 0;
        consume();

        // read with rlast=0 -> forced error response, data still returned
        rvalid = 1; rlast = 0; rdata = 128'h77; rresp = 2'b00;
        issue(1'b0, 6'h04, '0);
        tick(); tick();
        chk("r2_rlast_err", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1_10_0);
        chk("r2_rdata", rsp_rdata, 128'h77);
        consume();
        rvalid = 0; rlast = 1;

        // read timeout: no rvalid, TIMEOUT_CYCLES=8
        issue(1'b0, 6'h2C, '0);
        tick();
        chk("to_wait1", {rready, rsp_valid}, 2'b10);
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (i == 8) chk("to_wait8", {rready, rsp_valid}, 2'b10);
        end
        tick();
        chk("to_rsp", {rready, rsp_valid, rsp_resp, rsp_timeout}, 5'b0_1_10_1);
        chk("to_rdata", rsp_rdata, 0);
        rvalid = 1; rdata = 128'hBAD;
        tick();
        chk("to_late_r", {rready, rsp_valid, rsp_timeout}, 3'b011);
        chk("to_late_rdata", rsp_rdata, 0);
        consume();
        rvalid = 0;

        // reset asserted while waiting for B
        awready = 1; wready = 1; bvalid = 0;
        issue(1'b1, 6'h14, 128'h9);
        tick();
        chk("rst_mid_waitb", bready, 1);
        reset = 1'b1;
        tick();
        chk("rst_mid", {bready, cmd_ready, rsp_valid, awvalid, wvalid}, 5'b01000);
        reset = 1'b0;
        tick();
        chk("rst_mid_idle", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
